s2p_lane_arbiter: RTL and testbench
===================================

Name: s2p_lane_arbiter

Overview:
Shares one 8-bit serial-to-parallel deserializer between NUM_LANES serial requesters. A round-robin arbiter grants one lane per frame and routes that lane's bit stream onto the deserializer's din_serial/din_valid for exactly FRAME_BITS cycles. It then waits for the deserializer's dout_valid and presents the captured word, tagged with the lane index, on a valid/ready output port. A response timeout reports a deserializer that never answers.

Parameters:
NUM_LANES, 4, number of serial requesters (2..8)
FRAME_BITS, 8, bits per frame; equals deserializer output width
RESP_TIMEOUT, 4, max cycles in WAIT_RESP before error (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
lane_req  in  NUM_LANES  per-lane frame request, level
lane_serial  in  NUM_LANES  per-lane serial data bit
lane_grant  out  NUM_LANES  one-hot grant; high through GRANT and SHIFT
s2p_din  out  1  serial bit to deserializer (din_serial)
s2p_din_valid  out  1  bit-valid to deserializer (din_valid)
s2p_dout  in  FRAME_BITS  deserializer parallel word (dout_parallel)
s2p_dout_valid  in  1  deserializer word strobe (dout_valid)
out_data  out  FRAME_BITS  captured word
out_lane  out  clog2(NUM_LANES)  index of the lane that sent out_data
out_valid  out  1  out_data/out_lane valid; held until accepted
out_ready  in  1  downstream accept
out_err  out  1  one-cycle pulse on response timeout

Behaviour:
- Reset values: lane_grant=0, s2p_din=0, s2p_din_valid=0, out_data=0, out_lane=0, out_valid=0, out_err=0. State=IDLE, rr_last=NUM_LANES-1, so lane 0 has first priority.
- State machine: IDLE -> GRANT -> SHIFT -> WAIT_RESP -> OUTPUT -> IDLE. A timeout takes WAIT_RESP -> IDLE instead.
- IDLE:
  - lane_req is sampled only in IDLE.
  - If any bit is set, select the first requesting lane scanning from rr_last+1 with wrap-around.
  - Register it as sel, set lane_grant[sel], and go to GRANT.
  - If no bit is set, stay in IDLE.
- GRANT:
  - Exactly 1 cycle; s2p_din_valid=0.
  - The granted lane uses this cycle to drive its first bit.
- SHIFT:
  - Exactly FRAME_BITS cycles, counted by bit_cnt from 0 to FRAME_BITS-1.
  - s2p_din_valid=1 on every SHIFT cycle.
  - s2p_din = lane_serial[sel], combinational with no added latency. MSB is first, so the first bit lands in out_data[FRAME_BITS-1].
  - On the last SHIFT cycle: rr_last <= sel, lane_grant cleared, go to WAIT_RESP.
  - lane_req deasserting mid-frame is ignored; the frame always completes.
- WAIT_RESP:
  - s2p_din_valid=0. This mandatory gap resets the deserializer's bit counter between frames.
  - resp_cnt increments each cycle.
  - If s2p_dout_valid=1: out_data <= s2p_dout, out_lane <= sel, out_valid <= 1, go to OUTPUT.
  - If resp_cnt reaches RESP_TIMEOUT without dout_valid: pulse out_err for 1 cycle, go to IDLE, no output.
  - If dout_valid and timeout occur in the same cycle, dout_valid wins.
- OUTPUT:
  - out_valid, out_data and out_lane hold stable until out_valid && out_ready.
  - On acceptance: out_valid <= 0 next edge, go to IDLE.
  - No new grant is issued while out_valid=1; this is the backpressure path.
- s2p_dout_valid seen in any state other than WAIT_RESP is ignored.
- Minimum frame period, with out_ready tied high and a 1-cycle deserializer response: 1 (IDLE) + 1 (GRANT) + FRAME_BITS + 1 (WAIT_RESP) + 1 (OUTPUT) = FRAME_BITS+4 cycles.
- Reset mid-operation (async): all outputs go to reset values immediately and state returns to IDLE. The partial frame is discarded and rr_last returns to NUM_LANES-1.
- lane_grant is one-hot or zero at all times; s2p_din_valid=1 only in SHIFT.
- sel, rr_last and out_lane are clog2(NUM_LANES) bits wide; the wrap from NUM_LANES-1 goes to 0. bit_cnt and resp_cnt are 4 bits wide and clear on state entry.

Test Plan:
- Single lane: lane_req=4'b0100, lane 2 sends 8'hA5 MSB-first, deserializer model answers 1 cycle later -> s2p_din_valid high 8 cycles; out_valid with out_data=8'hA5, out_lane=2; lane_grant=4'b0100 for 9 cycles.
- Round-robin: lane_req=4'b1111 held, lanes send 8'h10..8'h13, out_ready=1 -> out_lane sequence 0,1,2,3,0; frames spaced exactly 12 cycles; s2p_din_valid low at least 1 cycle between frames.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_data/out_lane stable, lane_grant stays 0, no s2p_din_valid; out_ready=1 -> acceptance, then the next grant 1 cycle after IDLE.
- Timeout: deserializer model never asserts dout_valid -> out_err pulses once exactly RESP_TIMEOUT cycles after the last SHIFT; no out_valid; the next requester is granted.
- Req drop mid-frame: lane 1 deasserts lane_req after 3 SHIFT cycles -> all 8 bits still shifted, word output with out_lane=1.
- Async reset during SHIFT (bit 5) -> all outputs 0 immediately; after release with lane_req=4'b1010, lane 1 is granted first.

Source files
------------

// File: rtl/s2p_lane_arbiter_if.sv
// Bundle of lane, deserializer and output-port signals for s2p_lane_arbiter.
//
// Output handshake: out_valid/out_data/out_lane are driven by the arbiter and
// stay stable while out_valid=1 && out_ready=0; a word transfers on every
// rising clk edge where out_valid && out_ready are both high, and out_valid
// never depends combinationally on out_ready.
interface s2p_lane_arbiter_if #(
  parameter int NUM_LANES  = 4,
  parameter int FRAME_BITS = 8
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [NUM_LANES-1:0]  lane_req;
  logic [NUM_LANES-1:0]  lane_serial;
  logic [NUM_LANES-1:0]  lane_grant;
  logic                  s2p_din;
  logic                  s2p_din_valid;
  logic [FRAME_BITS-1:0] s2p_dout;
  logic                  s2p_dout_valid;
  logic [FRAME_BITS-1:0] out_data;
  logic [LW-1:0]         out_lane;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_err;

  // Arbiter side
  modport master (
    input  lane_req, lane_serial, s2p_dout, s2p_dout_valid, out_ready,
    output lane_grant, s2p_din, s2p_din_valid, out_data, out_lane, out_valid, out_err
  );

  // Environment side: lanes, deserializer and downstream consumer
  modport slave (
    output lane_req, lane_serial, s2p_dout, s2p_dout_valid, out_ready,
    input  lane_grant, s2p_din, s2p_din_valid, out_data, out_lane, out_valid, out_err
  );
endinterface

// File: rtl/s2p_lane_arbiter.sv
// Round-robin sharing of one serial-to-parallel deserializer between lanes.
// One lane is granted per frame, its bit stream is routed to the deserializer
// for FRAME_BITS cycles, and the returned word is presented tagged with the
// lane index. A deserializer that stays silent for RESP_TIMEOUT cycles in
// WAIT_RESP produces a one-cycle out_err pulse in the following cycle.
module s2p_lane_arbiter #(
  parameter int NUM_LANES    = 4,
  parameter int FRAME_BITS   = 8,
  parameter int RESP_TIMEOUT = 4,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  s2p_lane_arbiter_if.master    bus,
  output logic [2:0]            state_dbg_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    SHIFT     = 3'd2,
    WAIT_RESP = 3'd3,
    OUTPUT    = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [LW-1:0]         sel_q, sel_d;
  logic [LW-1:0]         rr_last_q, rr_last_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [3:0]            resp_cnt_q, resp_cnt_d;
  logic [FRAME_BITS-1:0] out_data_q, out_data_d;
  logic [LW-1:0]         out_lane_q, out_lane_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_err_q, out_err_d;

  logic                  pick_found;
  logic [LW-1:0]         pick_idx;
  logic [LW-1:0]         cand;

  // Round-robin pick: scan from rr_last+1 with wrap; nearest requester wins,
  // so the loop runs farthest-first and lets closer lanes overwrite.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_LANES; i >= 1; i--) begin
      cand = LW'((int'(rr_last_q) + i) % NUM_LANES);
      if (bus.lane_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rr_last_q   <= LW'(NUM_LANES - 1);
      bit_cnt_q   <= '0;
      resp_cnt_q  <= '0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_last_q   <= rr_last_d;
      bit_cnt_q   <= bit_cnt_d;
      resp_cnt_q  <= resp_cnt_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  // Next-state and register updates for the frame sequence
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_last_d   = rr_last_q;
    bit_cnt_d   = bit_cnt_q;
    resp_cnt_d  = resp_cnt_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    out_valid_d = out_valid_q;
    out_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
          rr_last_d  = sel_q;
          resp_cnt_d = '0;
          state_d    = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        resp_cnt_d = resp_cnt_q + 4'd1;
        // A response in the final allowed cycle still wins over the timeout
        if (bus.s2p_dout_valid) begin
          out_data_d  = bus.s2p_dout;
          out_lane_d  = sel_q;
          out_valid_d = 1'b1;
          state_d     = OUTPUT;
        end else if (resp_cnt_q == 4'(RESP_TIMEOUT - 1)) begin
          out_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant and serial routing follow the registered state and selection
  always_comb begin
    bus.lane_grant = '0;
    if (state_q == GRANT || state_q == SHIFT) begin
      bus.lane_grant[sel_q] = 1'b1;
    end
  end

  assign bus.s2p_din_valid = (state_q == SHIFT);
  assign bus.s2p_din       = (state_q == SHIFT) & bus.lane_serial[sel_q];
  assign bus.out_data      = out_data_q;
  assign bus.out_lane      = out_lane_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_err       = out_err_q;
  assign state_dbg_o       = state_q;

endmodule

// File: tb/tb_s2p_lane_arbiter.sv
// Directed bench for s2p_lane_arbiter with lane sources and a deserializer model.
module tb_s2p_lane_arbiter;
  localparam int NL = 4;
  localparam int FB = 8;
  localparam int RT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  logic [2:0] state_dbg;
  s2p_lane_arbiter_if #(.NUM_LANES(NL), .FRAME_BITS(FB)) bus ();
  s2p_lane_arbiter #(.NUM_LANES(NL), .FRAME_BITS(FB), .RESP_TIMEOUT(RT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .state_dbg_o(state_dbg)
  );

  // ---------------- environment models ----------------
  logic [FB-1:0] lane_word [NL];
  logic [FB-1:0] lane_sh   [NL];
  logic          des_en;
  logic [FB-1:0] des_sr;
  logic [3:0]    des_cnt;

  // Each lane presents its word MSB-first, advancing one bit per accepted bit
  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (!bus.lane_grant[l]) lane_sh[l] <= lane_word[l];
      else if (bus.s2p_din_valid) lane_sh[l] <= lane_sh[l] << 1;
    end
  end

  always_comb begin
    bus.lane_serial = '0;
    for (int l = 0; l < NL; l++) bus.lane_serial[l] = lane_sh[l][FB-1];
  end

  // Deserializer: collects FB valid bits, answers with the word one cycle later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      des_sr <= '0; des_cnt <= '0;
      bus.s2p_dout <= '0; bus.s2p_dout_valid <= 1'b0;
    end else begin
      bus.s2p_dout_valid <= 1'b0;
      if (bus.s2p_din_valid) begin
        des_sr <= {des_sr[FB-2:0], bus.s2p_din};
        if (des_cnt == 4'(FB - 1)) begin
          des_cnt <= '0;
          if (des_en) begin
            bus.s2p_dout       <= {des_sr[FB-2:0], bus.s2p_din};
            bus.s2p_dout_valid <= 1'b1;
          end
        end else begin
          des_cnt <= des_cnt + 4'd1;
        end
      end else begin
        des_cnt <= '0;
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [FB-1:0] exp_q [$];

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    bus.lane_req = '0;
    bus.out_ready = 1'b1;
    des_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Watch one frame until out_valid; optionally drop lane_req once granted
  task automatic watch_frame(input int budget, input bit drop,
                             output bit got, output int dv_n, output int g_n,
                             output logic [NL-1:0] g_seen, output int oh_bad,
                             output logic [FB-1:0] bits);
    got = 1'b0; dv_n = 0; g_n = 0; g_seen = '0; oh_bad = 0; bits = '0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (bus.lane_grant != '0) begin
        g_n++;
        g_seen |= bus.lane_grant;
        if ($countones(bus.lane_grant) != 1) oh_bad++;
        if (drop) bus.lane_req = '0;
      end
      if (bus.s2p_din_valid) begin
        dv_n++;
        bits = {bits[FB-2:0], bus.s2p_din};
      end
      if (bus.out_valid) got = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_vec++; if (bus.lane_grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b, expected 0000", bus.lane_grant); end
    n_vec++; if (bus.s2p_din_valid !== 1'b0) begin n_err++; $display("FAIL reset_din_valid: got %b, expected 0", bus.s2p_din_valid); end
    n_vec++; if (bus.s2p_din !== 1'b0) begin n_err++; $display("FAIL reset_din: got %b, expected 0", bus.s2p_din); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
    n_vec++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h, expected 00", bus.out_data); end
    n_vec++; if (bus.out_lane !== 2'd0) begin n_err++; $display("FAIL reset_out_lane: got %0d, expected 0", bus.out_lane); end
    n_vec++; if (bus.out_err !== 1'b0) begin n_err++; $display("FAIL reset_out_err: got %b, expected 0", bus.out_err); end
    n_vec++; if (state_dbg !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d, expected 0", state_dbg); end
  endtask

  task automatic test_single_lane();
    bit got; int dv_n, g_n, oh_bad; logic [NL-1:0] g_seen; logic [FB-1:0] bits;
    do_reset();
    lane_word[2] = 8'hA5;
    bus.lane_req = 4'b0100;
    watch_frame(40, 1'b1, got, dv_n, g_n, g_seen, oh_bad, bits);
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL single_out_valid: got %b, expected 1", got); end
    n_vec++; if (dv_n != 8) begin n_err++; $display("FAIL single_din_valid_cycles: got %0d, expected 8", dv_n); end
    n_vec++; if (g_n != 9) begin n_err++; $display("FAIL single_grant_cycles: got %0d, expected 9", g_n); end
    n_vec++; if (g_seen !== 4'b0100 || oh_bad != 0) begin n_err++; $display("FAIL single_grant_lane: got %b (bad %0d), expected 0100", g_seen, oh_bad); end
    n_vec++; if (bits !== 8'hA5) begin n_err++; $display("FAIL single_serial_bits: got %h, expected a5", bits); end
    n_vec++; if (bus.out_data !== 8'hA5) begin n_err++; $display("FAIL single_out_data: got %h, expected a5", bus.out_data); end
    n_vec++; if (bus.out_lane !== 2'd2) begin n_err++; $display("FAIL single_out_lane: got %0d, expected 2", bus.out_lane); end
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_out_valid_drop: got %b, expected 0", bus.out_valid); end
  endtask

  task automatic test_round_robin();
    bit got; int dv_n, g_n, oh_bad; logic [NL-1:0] g_seen; logic [FB-1:0] bits;
    logic [1:0] exp_lane [5];
    int t_prev;
    logic [FB-1:0] exp_w;
    exp_lane[0] = 2'd0; exp_lane[1] = 2'd1; exp_lane[2] = 2'd2; exp_lane[3] = 2'd3; exp_lane[4] = 2'd0;
    do_reset();
    lane_word[0] = 8'h10; lane_word[1] = 8'h11; lane_word[2] = 8'h12; lane_word[3] = 8'h13;
    exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
    exp_q.push_back(8'h13); exp_q.push_back(8'h10);
    bus.lane_req = 4'b1111;
    t_prev = 0;
    for (int f = 0; f < 5; f++) begin
      watch_frame(40, 1'b0, got, dv_n, g_n, g_seen, oh_bad, bits);
      exp_w = exp_q.pop_front();
      n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL rr_out_valid[%0d]: got %b, expected 1", f, got); end
      n_vec++; if (bus.out_lane !== exp_lane[f]) begin n_err++; $display("FAIL rr_out_lane[%0d]: got %0d, expected %0d", f, bus.out_lane, exp_lane[f]); end
      n_vec++; if (bus.out_data !== exp_w) begin n_err++; $display("FAIL rr_out_data[%0d]: got %h, expected %h", f, bus.out_data, exp_w); end
      n_vec++; if (dv_n != 8) begin n_err++; $display("FAIL rr_din_valid_cycles[%0d]: got %0d, expected 8", f, dv_n); end
      if (f > 0) begin
        n_vec++; if (cyc - t_prev != 12) begin n_err++; $display("FAIL rr_spacing[%0d]: got %0d, expected 12", f, cyc - t_prev); end
      end
      t_prev = cyc;
    end
    bus.lane_req = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit got; int dv_n, g_n, oh_bad; logic [NL-1:0] g_seen; logic [FB-1:0] bits;
    int viol;
    do_reset();
    lane_word[0] = 8'h3C;
    bus.out_ready = 1'b0;
    bus.lane_req = 4'b0001;
    watch_frame(40, 1'b0, got, dv_n, g_n, g_seen, oh_bad, bits);
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: got %b, expected 1", got); end
    n_vec++; if (bus.out_data !== 8'h3C) begin n_err++; $display("FAIL bp_out_data: got %h, expected 3c", bus.out_data); end
    lane_word[0] = 8'hC3;
    viol = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.out_lane !== 2'd0 ||
          bus.lane_grant !== 4'b0000 || bus.s2p_din_valid !== 1'b0) viol++;
    end
    n_vec++; if (viol != 0) begin n_err++; $display("FAIL bp_hold_stable: got %0d bad cycles, expected 0", viol); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0 || bus.lane_grant !== 4'b0000) begin n_err++; $display("FAIL bp_accept_idle: got valid=%b grant=%b, expected valid=0 grant=0000", bus.out_valid, bus.lane_grant); end
    @(negedge clk);
    n_vec++; if (bus.lane_grant !== 4'b0001) begin n_err++; $display("FAIL bp_next_grant: got %b, expected 0001", bus.lane_grant); end
    bus.lane_req = '0;
    watch_frame(40, 1'b0, got, dv_n, g_n, g_seen, oh_bad, bits);
    n_vec++; if (got !== 1'b1 || bus.out_data !== 8'hC3) begin n_err++; $display("FAIL bp_second_word: got %h (valid %b), expected c3", bus.out_data, got); end
  endtask

  task automatic test_timeout();
    int t_last_dv, t_err, err_n, ov_n;
    logic [NL-1:0] first_g, next_g;
    bit done;
    do_reset();
    des_en = 1'b0;
    lane_word[1] = 8'h11; lane_word[3] = 8'h33;
    bus.lane_req = 4'b1010;
    t_last_dv = -1; t_err = -1; err_n = 0; ov_n = 0; first_g = '0; next_g = '0; done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (first_g == '0) first_g = bus.lane_grant;
      if (bus.s2p_din_valid) t_last_dv = cyc;
      if (bus.out_valid) ov_n++;
      if (bus.out_err) begin
        if (t_err < 0) t_err = cyc;
        err_n++;
      end
      if (t_err >= 0 && bus.lane_grant != '0) begin
        next_g = bus.lane_grant;
        done = 1'b1;
      end
    end
    n_vec++; if (first_g !== 4'b0010) begin n_err++; $display("FAIL to_first_grant: got %b, expected 0010", first_g); end
    n_vec++; if (t_err < 0) begin n_err++; $display("FAIL to_err_seen: got none, expected one pulse"); end
    n_vec++; if (t_err - t_last_dv != RT + 1) begin n_err++; $display("FAIL to_err_latency: got %0d, expected %0d", t_err - t_last_dv, RT + 1); end
    n_vec++; if (err_n != 1) begin n_err++; $display("FAIL to_err_width: got %0d, expected 1", err_n); end
    n_vec++; if (ov_n != 0) begin n_err++; $display("FAIL to_no_output: got %0d valid cycles, expected 0", ov_n); end
    n_vec++; if (next_g !== 4'b1000) begin n_err++; $display("FAIL to_next_grant: got %b, expected 1000", next_g); end
    bus.lane_req = '0;
  endtask

  task automatic test_req_drop();
    int dv_n; bit got; logic [FB-1:0] bits;
    do_reset();
    lane_word[1] = 8'h5A;
    bus.lane_req = 4'b0010;
    dv_n = 0; got = 1'b0; bits = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.s2p_din_valid) begin
        dv_n++;
        bits = {bits[FB-2:0], bus.s2p_din};
        if (dv_n == 3) bus.lane_req = '0;
      end
      if (bus.out_valid) got = 1'b1;
    end
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL drop_out_valid: got %b, expected 1", got); end
    n_vec++; if (dv_n != 8) begin n_err++; $display("FAIL drop_bits_shifted: got %0d, expected 8", dv_n); end
    n_vec++; if (bits !== 8'h5A) begin n_err++; $display("FAIL drop_serial_bits: got %h, expected 5a", bits); end
    n_vec++; if (bus.out_data !== 8'h5A || bus.out_lane !== 2'd1) begin n_err++; $display("FAIL drop_output: got %h lane %0d, expected 5a lane 1", bus.out_data, bus.out_lane); end
    repeat (3) @(negedge clk);
    n_vec++; if (bus.lane_grant !== 4'b0000) begin n_err++; $display("FAIL drop_no_regrant: got %b, expected 0000", bus.lane_grant); end
  endtask

  task automatic test_async_reset();
    int dv_n; bit got; int dv2, g_n, oh_bad; logic [NL-1:0] g_seen; logic [FB-1:0] bits;
    do_reset();
    lane_word[0] = 8'hFF;
    bus.lane_req = 4'b0001;
    dv_n = 0;
    for (int k = 0; k < 40 && dv_n < 6; k++) begin
      @(negedge clk);
      if (bus.s2p_din_valid) dv_n++;
    end
    n_vec++; if (dv_n != 6 || bus.s2p_din !== 1'b1) begin n_err++; $display("FAIL ar_mid_frame: got bits=%0d din=%b, expected 6 and 1", dv_n, bus.s2p_din); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.lane_grant !== 4'b0000) begin n_err++; $display("FAIL ar_grant: got %b, expected 0000", bus.lane_grant); end
    n_vec++; if (bus.s2p_din_valid !== 1'b0 || bus.s2p_din !== 1'b0) begin n_err++; $display("FAIL ar_din: got valid=%b din=%b, expected 0 0", bus.s2p_din_valid, bus.s2p_din); end
    n_vec++; if (bus.out_valid !== 1'b0 || bus.out_err !== 1'b0) begin n_err++; $display("FAIL ar_out: got valid=%b err=%b, expected 0 0", bus.out_valid, bus.out_err); end
    n_vec++; if (state_dbg !== 3'd0) begin n_err++; $display("FAIL ar_state: got %0d, expected 0", state_dbg); end
    lane_word[1] = 8'h77; lane_word[3] = 8'h99;
    bus.lane_req = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.lane_grant !== 4'b0010) begin n_err++; $display("FAIL ar_first_grant: got %b, expected 0010", bus.lane_grant); end
    bus.lane_req = '0;
    watch_frame(40, 1'b0, got, dv2, g_n, g_seen, oh_bad, bits);
    n_vec++; if (got !== 1'b1 || bus.out_data !== 8'h77 || bus.out_lane !== 2'd1) begin n_err++; $display("FAIL ar_frame_after: got %h lane %0d valid %b, expected 77 lane 1", bus.out_data, bus.out_lane, got); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    bus.lane_req = '0;
    bus.out_ready = 1'b1;
    des_en = 1'b1;
    for (int l = 0; l < NL; l++) lane_word[l] = '0;
    rst_n = 1'b0;
    test_reset();
    test_single_lane();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_req_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
